// File: rtl/joyquad_pkg.sv
// Shared types, Gray-phase constants and width helpers for the joyquad encoder.
// Acceleration is compiled in only when JOYQUAD_ACCEL_EN is defined.
package joyquad_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CW   = 2'd1,
    CCW  = 2'd2
  } dir_t;

  localparam logic [1:0] PH0 = 2'b00;
  localparam logic [1:0] PH1 = 2'b01;
  localparam logic [1:0] PH2 = 2'b11;
  localparam logic [1:0] PH3 = 2'b10;

  // One Gray step along the quadrature wheel; IDLE leaves the phase alone.
  function automatic logic [1:0] next_phase(input logic [1:0] phase, input dir_t d);
    logic [1:0] n;
    n = phase;
    case (d)
      CW: begin
        case (phase)
          PH0:     n = PH1;
          PH1:     n = PH2;
          PH2:     n = PH3;
          default: n = PH0;
        endcase
      end
      CCW: begin
        case (phase)
          PH0:     n = PH3;
          PH3:     n = PH2;
          PH2:     n = PH1;
          default: n = PH0;
        endcase
      end
      default: n = phase;
    endcase
    return n;
  endfunction

  function automatic int log2_ceil(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    if (r < 1) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/joyquad_chan.sv
// One quadrature channel: request decode, prescaler, Gray phase and optional
// acceleration (JOYQUAD_ACCEL_EN).
module joyquad_chan
  import joyquad_pkg::*;
#(
  parameter int DIV_W     = 16,
  parameter int ACC_STEPS = 4,
  parameter int ACC_HOLD  = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [DIV_W-1:0] clkdiv_i,
  input  logic             right_i,
  input  logic             left_i,
  input  logic             invert_i,
  output logic [1:0]       steer_o,
  output logic             step_pulse_o,
  output logic             dir_o
);

  localparam logic [DIV_W-1:0] DIV_ONE = DIV_W'(1);

  if (ACC_STEPS < 1 || ACC_STEPS > DIV_W || ACC_HOLD < 1) begin : g_bad_acc
    $error("joyquad_chan: ACC_STEPS must be 1..DIV_W and ACC_HOLD at least 1");
  end

  dir_t             cur, req_q;
  logic [DIV_W-1:0] presc_q, presc_d, shifted, period;
  logic [1:0]       phase_q, phase_d;
  logic             pulse_q, pulse_d, dir_q, dir_d;
  logic             active, wrap;

`ifdef JOYQUAD_ACCEL_EN
  localparam int LVL_W = log2_ceil(ACC_STEPS);
  localparam int CNT_W = log2_ceil(ACC_HOLD);
  localparam logic [LVL_W-1:0] LVL_MAX = LVL_W'(ACC_STEPS - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(ACC_HOLD - 1);

  logic [LVL_W-1:0] level_q, level_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign shifted = clkdiv_i >> level_q;
`else
  assign shifted = clkdiv_i;
`endif

  // A fresh request or a direct reversal spends one cycle looking idle so it counts from 0.
  always_comb begin
    cur = IDLE;
    if (right_i && !left_i)      cur = invert_i ? CCW : CW;
    else if (left_i && !right_i) cur = invert_i ? CW : CCW;

    period  = (shifted == '0) ? DIV_ONE : shifted;
    active  = (cur != IDLE) && (cur == req_q) && (clkdiv_i != '0);
    wrap    = active && (presc_q >= period - DIV_ONE);

    presc_d = active ? presc_q + DIV_ONE : '0;
    phase_d = phase_q;
    pulse_d = 1'b0;
    dir_d   = dir_q;
    if (wrap) begin
      presc_d = '0;
      phase_d = next_phase(phase_q, cur);
      pulse_d = 1'b1;
      dir_d   = (cur == CW);
    end

`ifdef JOYQUAD_ACCEL_EN
    level_d = level_q;
    cnt_d   = cnt_q;
    if (!active) begin
      level_d = '0;
      cnt_d   = '0;
    end else if (wrap && level_q != LVL_MAX) begin
      if (cnt_q == CNT_MAX) begin
        level_d = level_q + 1'b1;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      req_q   <= IDLE;
      presc_q <= '0;
      phase_q <= PH0;
      pulse_q <= 1'b0;
      dir_q   <= 1'b0;
`ifdef JOYQUAD_ACCEL_EN
      level_q <= '0;
      cnt_q   <= '0;
`endif
    end else begin
      req_q   <= cur;
      presc_q <= presc_d;
      phase_q <= phase_d;
      pulse_q <= pulse_d;
      dir_q   <= dir_d;
`ifdef JOYQUAD_ACCEL_EN
      level_q <= level_d;
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign steer_o      = phase_q;
  assign step_pulse_o = pulse_q;
  assign dir_o        = dir_q;

endmodule

// File: rtl/joyquad_multi.sv
// Multi-channel digital-to-quadrature encoder for spinner/paddle emulation.
// Define JOYQUAD_ACCEL_EN to build the step-rate acceleration.
module joyquad_multi
  import joyquad_pkg::*;
#(
  parameter int CHANNELS  = 2,
  parameter int DIV_W     = 16,
  parameter int ACC_STEPS = 4,
  parameter int ACC_HOLD  = 8
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [DIV_W-1:0]      clkdiv,
  input  logic [CHANNELS-1:0]   right,
  input  logic [CHANNELS-1:0]   left,
  input  logic [CHANNELS-1:0]   invert,
  output logic [2*CHANNELS-1:0] steer,
  output logic [CHANNELS-1:0]   step_pulse,
  output logic [CHANNELS-1:0]   dir
);

  if (CHANNELS < 1 || CHANNELS > 8) begin : g_bad_channels
    $error("joyquad_multi: CHANNELS must be 1..8");
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    joyquad_chan #(
      .DIV_W    (DIV_W),
      .ACC_STEPS(ACC_STEPS),
      .ACC_HOLD (ACC_HOLD)
    ) u_chan (
      .clk_i       (CLK),
      .rst_i       (RESET),
      .clkdiv_i    (clkdiv),
      .right_i     (right[i]),
      .left_i      (left[i]),
      .invert_i    (invert[i]),
      .steer_o     (steer[2*i +: 2]),
      .step_pulse_o(step_pulse[i]),
      .dir_o       (dir[i])
    );
  end

endmodule

// File: doc/joyquad_multi.md
# joyquad_multi

Multi-channel digital-to-quadrature encoder for arcade spinner and paddle emulation. It converts per-channel left/right requests from keyboard or joystick into 2-bit Gray-code quadrature outputs at a programmable step rate. With acceleration compiled in, the step rate ramps up while a direction is held. It sits in the emu top level between the input mapping logic and the core's encoder inputs (Enc_A/Enc_B), one channel per player.

## Interface
Parameters:
- CHANNELS, 2, number of independent encoder channels (1..8)
- DIV_W, 16, width of the step-period divider
- ACC_STEPS, 4, number of acceleration levels (1..DIV_W)
- ACC_HOLD, 8, consecutive steps spent at a level before moving up

Ports:
- CLK  in  1  core clock (clk_sys); the only clock
- RESET  in  1  synchronous, active-high reset
- clkdiv  in  DIV_W  base step period in CLK cycles; 0 disables stepping on all channels
- right  in  CHANNELS  per-channel clockwise request, synchronous to CLK
- left  in  CHANNELS  per-channel counter-clockwise request, synchronous to CLK
- invert  in  CHANNELS  per-channel direction swap
- steer  out  2*CHANNELS  channel i at [2i+1:2i], {A,B}
- step_pulse  out  CHANNELS  one-cycle strobe on each quadrature step
- dir  out  CHANNELS  direction of the last step (1 = CW)

## Operation
- Inputs are not synchronised by this block. Callers provide CLK-domain signals.
- Per channel, the request is decoded as follows, then XORed with invert[i]:
  - right & ~left gives CW.
  - left & ~right gives CCW.
  - Both set, or neither set, gives IDLE.
- IDLE: the prescaler is held at 0 and the acceleration level and step count are cleared. steer holds its phase.
- Active: the prescaler increments each cycle. When it reaches period-1 it wraps to 0, the phase advances one step, step_pulse pulses, and dir updates.
- Phase sequence:
  - CW: 00 -> 01 -> 11 -> 10 -> 00.
  - CCW: the reverse order.
  - Only one bit changes per step.
- period = max(clkdiv >> level, 1). When clkdiv is 0, no steps occur and the prescaler is held at 0.
- Direction reversal (CW to CCW directly) behaves as IDLE for that cycle. The prescaler and level clear, and the new direction counts from 0.
- A change to clkdiv takes effect on the next prescaler compare. If the prescaler is already at or above the new period-1, it wraps on the next cycle.
- Channels are fully independent and share only clkdiv.

## Timing
- RESET values: steer=0, step_pulse=0, dir=0, prescaler=0, level=0, step count=0.
- A request first sampled at edge k produces its first step (steer change and step_pulse) at edge k+period. Subsequent steps follow every period cycles.
- steer and step_pulse are registered and change on the same edge. dir is valid on that same edge.
- RESET asserted mid-operation clears everything on that edge, regardless of requests.
- A request that drops on the same edge as the prescaler wrap produces no step.

## Configuration
- JOYQUAD_ACCEL_EN
  - Defined: acceleration is active. After ACC_HOLD consecutive steps at a level, the level increments, saturating at ACC_STEPS-1. The step count clears on each level change.
  - Undefined: level is constantly 0, period is max(clkdiv,1), and the acceleration counters are not synthesised. ACC_STEPS and ACC_HOLD are ignored.

## Structure
- Package joyquad_pkg holds:
  - the dir_t enum (IDLE, CW, CCW)
  - the Gray-phase constants
  - a next_phase(phase, dir_t) function
  - the log2 helper used for level and step-count widths
- Sub-module joyquad_chan implements one channel (prescaler, phase, acceleration). The top level generates CHANNELS instances and packs steer.

## Test plan
- clkdiv=4, right[0] held from cycle 0, accel off: steer[1:0] reads 01@4, 11@8, 10@12, 00@16. step_pulse[0] is high exactly on those cycles and dir[0]=1.
- clkdiv=4, left[1] held: steer[3:2] reads 10@4, 11@8, 01@12. dir[1]=0 and channel 0 stays 00.
- Both right[0] and left[0] held, clkdiv=4, for 100 cycles: no step_pulse and steer is unchanged. Setting invert[0]=1 with right held gives CCW order (10 first).
- JOYQUAD_ACCEL_EN, clkdiv=16, ACC_HOLD=2, ACC_STEPS=3, right held:
  - steps land at 16, 32, 40, 48, 52, 56, 60, 64.
  - releasing the input and re-pressing restarts at a 16-cycle period.
- Mid-run events, clkdiv=8:
  - Assert RESET at cycle 20: all outputs are 0 on the next edge.
  - Reverse direction at cycle 5 after a step: the next step is 8 cycles after the reversal.
  - Setting clkdiv=0 stops all steps.
